shift_seq_unit: RTL and testbench

SHIFT_SEQ_UNIT -- requirements
Module: shift_seq_unit

---
 rtl/shift_pkg.sv | 28 ++
 rtl/shift_step.sv | 22 ++
 rtl/shift_seq_unit.sv | 80 ++++++++
 tb/tb_shift_seq_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared encodings for the sequential shifter: operation codes, FSM states,
// and a helper that identifies the pass-through operation codes.
package shift_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [2:0] {
    OP_SLL  = 3'b000,
    OP_SRL  = 3'b001,
    OP_SRA  = 3'b010,
    OP_ROR  = 3'b011,
    OP_ROL  = 3'b100,
    OP_PASS = 3'b111
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // Codes 101..111 all behave as pass-through
  function automatic logic is_pass(input logic [2:0] op);
    return (op >= 3'b101);
  endfunction

endpackage

// File: rtl/shift_step.sv
// Purely combinational one-bit shift/rotate of a 32-bit value.
module shift_step
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0] value,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = value;
    case (op)
      OP_SLL:  result = {value[DATA_W-2:0], 1'b0};
      OP_SRL:  result = {1'b0, value[DATA_W-1:1]};
      OP_SRA:  result = {value[DATA_W-1], value[DATA_W-1:1]};
      OP_ROR:  result = {value[0], value[DATA_W-1:1]};
      OP_ROL:  result = {value[DATA_W-2:0], value[DATA_W-1]};
      default: result = value;
    endcase
  end

endmodule

// File: rtl/shift_seq_unit.sv
// Multi-cycle shifter: latches an operand, then shifts it one bit per clock
// until the latched amount is exhausted, pulsing done for one cycle.
module shift_seq_unit
  import shift_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [2:0]          op,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [SHAMT_W-1:0]  in_shamt,
  output logic [DATA_W-1:0]   out,
  output logic                busy,
  output logic                done
);

  state_e              state, state_next;
  logic [DATA_W-1:0]   out_next;
  logic [DATA_W-1:0]   stepped;
  logic [2:0]          op_q, op_next;
  logic [SHAMT_W-1:0]  count, count_next;

  // The step only ever sees registered state, so out has no input-to-output path
  shift_step u_step (
    .value  (out),
    .op     (op_q),
    .result (stepped)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      out   <= '0;
      op_q  <= OP_SLL;
      count <= '0;
    end else begin
      state <= state_next;
      out   <= out_next;
      op_q  <= op_next;
      count <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    out_next   = out;
    op_next    = op_q;
    count_next = count;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          out_next   = in_data;
          op_next    = op;
          count_next = in_shamt;
          if ((in_shamt == '0) || is_pass(op)) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_SHIFT;
          end
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        out_next   = stepped;
        count_next = count - 5'd1;
        if (count == 5'd1) begin
          state_next = ST_DONE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign busy = (state == ST_SHIFT);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_shift_seq_unit.sv
// Scoreboard bench for shift_seq_unit: expected results are queued at launch
// and compared when done pulses.
module tb_shift_seq_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [31:0] out;
  logic        busy;
  logic        done;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [31:0] value;
    int          cycles;
    string       name;
  } exp_t;

  exp_t sb[$];

  shift_seq_unit dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .in_data  (in_data),
    .in_shamt (in_shamt),
    .out      (out),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: whole-amount shift using language operators
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] d, input logic [4:0] n);
    int s;
    s = int'(n);
    case (o)
      3'b000:  return d << s;
      3'b001:  return d >> s;
      3'b010:  return 32'($signed(d) >>> s);
      3'b011:  return (s == 0) ? d : ((d >> s) | (d << (32 - s)));
      3'b100:  return (s == 0) ? d : ((d << s) | (d >> (32 - s)));
      default: return d;
    endcase
  endfunction

  // Called at a negedge; the following posedge is the accepting edge
  task automatic drive_op(input logic [2:0] o, input logic [31:0] d, input logic [4:0] n, input string name);
    exp_t e;
    start    = 1'b1;
    op       = o;
    in_data  = d;
    in_shamt = n;
    e.value  = model(o, d, n);
    e.cycles = ((n == 5'd0) || (o >= 3'b101)) ? 0 : int'(n);
    e.name   = name;
    sb.push_back(e);
    @(negedge clk);
    start    = 1'b0;
    in_data  = ~d;
    op       = 3'($urandom_range(0, 7));
    in_shamt = 5'($urandom_range(0, 31));
  endtask

  // Walks cycles until done; flags any idle cycle, overlap or timeout in bad
  task automatic wait_result(input int poke_at, output logic [31:0] got, output int waits,
                             output int busy_n, output bit bad);
    bad    = 1'b0;
    waits  = 0;
    busy_n = 0;
    got    = 'x;
    for (int i = 0; i < 100; i++) begin
      if (done === 1'b1) begin
        got = out;
        if (busy !== 1'b0) bad = 1'b1;
        return;
      end
      if (busy === 1'b1) busy_n++;
      else bad = 1'b1;
      waits++;
      if (i == poke_at) begin
        start    = 1'b1;
        in_data  = $urandom;
        op       = 3'($urandom_range(0, 7));
        in_shamt = 5'($urandom_range(0, 31));
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    bad = 1'b1;
  endtask

  task automatic test_reset();
    tests_run++;
    if (out !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_out: got %h expected %h", out, 32'h0);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_busy: got %b expected 0", busy);
    end
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_done: got %b expected 0", done);
    end
  endtask

  // Launches one operation and scores it against the queue head
  task automatic test_ops(input logic [2:0] o, input logic [31:0] d, input logic [4:0] n,
                          input int poke_at, input string name);
    logic [31:0] got;
    int          waits, busy_n;
    bit          bad;
    exp_t        e;
    drive_op(o, d, n, name);
    wait_result(poke_at, got, waits, busy_n, bad);
    e = sb.pop_front();
    tests_run++;
    if (bad !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL %s_protocol: got idle/overlap/timeout expected clean busy-then-done", e.name);
    end
    tests_run++;
    if (got !== e.value) begin
      tests_failed++;
      $display("[TB] FAIL %s_out: got %h expected %h", e.name, got, e.value);
    end
    tests_run++;
    if (waits !== e.cycles || busy_n !== e.cycles) begin
      tests_failed++;
      $display("[TB] FAIL %s_latency: got waits=%0d busy=%0d expected %0d", e.name, waits, busy_n, e.cycles);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got;
    int          waits, busy_n;
    bit          bad;
    exp_t        e;
    logic [2:0]  ops[3]    = '{3'b000, 3'b011, 3'b010};
    logic [31:0] datas[3]  = '{32'h0000_0001, 32'h0000_0001, 32'hF000_0000};
    logic [4:0]  shamts[3] = '{5'd2, 5'd3, 5'd0};
    for (int k = 0; k < 3; k++) begin
      drive_op(ops[k], datas[k], shamts[k], $sformatf("b2b%0d", k));
      wait_result(-1, got, waits, busy_n, bad);
      e = sb.pop_front();
      tests_run++;
      if (bad !== 1'b0 || got !== e.value || waits !== e.cycles) begin
        tests_failed++;
        $display("[TB] FAIL %s: got out=%h waits=%0d bad=%0b expected out=%h waits=%0d",
                 e.name, got, waits, bad, e.value, e.cycles);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_shift();
    bit seen;
    drive_op(3'b000, 32'h0000_0001, 5'd20, "abort");
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    void'(sb.pop_back());
    tests_run++;
    if (out !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL abort_immediate: got out=%h busy=%b done=%b expected 0/0/0", out, busy, done);
    end
    @(negedge clk);
    reset = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL abort_quiet: got activity after abort expected none");
    end
    test_ops(3'b100, 32'h8000_0001, 5'd1, -1, "after_abort");
    @(negedge clk);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    op       = 3'b000;
    in_data  = 32'h0;
    in_shamt = 5'd0;
    repeat (2) @(negedge clk);
    test_reset();
    reset = 1'b0;
    @(negedge clk);

    test_ops(3'b000, 32'h0000_0001, 5'd4,  -1, "sll4");
    @(negedge clk);
    test_ops(3'b010, 32'h8000_0000, 5'd31, -1, "sra31");
    @(negedge clk);
    test_ops(3'b001, 32'h8000_0000, 5'd31, -1, "srl31");
    @(negedge clk);
    test_ops(3'b011, 32'h0000_0001, 5'd1,  -1, "ror1");
    @(negedge clk);
    test_ops(3'b100, 32'h8000_0001, 5'd1,  -1, "rol1");
    @(negedge clk);
    test_ops(3'b001, 32'hDEAD_BEEF, 5'd0,  -1, "srl0");
    @(negedge clk);
    test_ops(3'b111, 32'hDEAD_BEEF, 5'd9,  -1, "pass9");
    @(negedge clk);
    test_ops(3'b000, 32'h0000_0001, 5'd8,   3, "start_ignored");
    @(negedge clk);
    test_back_to_back();
    test_reset_mid_shift();
    for (int r = 0; r < 6; r++) begin
      test_ops(3'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 31)), -1, $sformatf("rand%0d", r));
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
